// File: rtl/click_tone_generator.sv
// Turns each one-cycle beat strobe into a fixed-length square-wave burst on an idle-high
// speaker pin. Accented beats use the higher pitch; mute blocks new bursts and stops a running one.
module click_tone_generator #(
    parameter int unsigned FREQ      = 24_000_000,
    parameter int unsigned TONE_HZ   = 880,
    parameter int unsigned ACCENT_HZ = 1760,
    parameter int unsigned BEEP_MS   = 60
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic beat,
    input  logic accent,
    input  logic mute,
    output logic speaker,
    output logic busy
);

    localparam int unsigned HALF_N      = FREQ / (2 * TONE_HZ);
    localparam int unsigned HALF_A      = FREQ / (2 * ACCENT_HZ);
    localparam int unsigned BEEP_CYCLES = (FREQ / 1000) * BEEP_MS;
    localparam int unsigned HALF_MAX    = (HALF_N > HALF_A) ? HALF_N : HALF_A;
    localparam int unsigned PW          = $clog2(HALF_MAX + 1);
    localparam int unsigned DW          = $clog2(BEEP_CYCLES + 1);

    if (HALF_N < 1 || HALF_A < 1 || BEEP_CYCLES < 2) begin : g_param_check
        $error("click_tone_generator: HALF_N/HALF_A must be >= 1 and BEEP_CYCLES >= 2");
    end

    typedef enum logic {IDLE, TONE} state_t;

    state_t        state, state_d;
    logic [PW-1:0] phase_cnt, phase_d;
    logic [DW-1:0] dur_cnt, dur_d;
    logic          accent_q, accent_d;
    logic          speaker_d, busy_d;
    logic [PW-1:0] half_last;

    assign half_last = accent_q ? PW'(HALF_A - 1) : PW'(HALF_N - 1);

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            dur_cnt   <= '0;
            accent_q  <= 1'b0;
            speaker   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            phase_cnt <= phase_d;
            dur_cnt   <= dur_d;
            accent_q  <= accent_d;
            speaker   <= speaker_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic; mute outranks retrigger, which outranks counting
    always_comb begin
        state_d   = state;
        phase_d   = phase_cnt;
        dur_d     = dur_cnt;
        accent_d  = accent_q;
        speaker_d = speaker;
        busy_d    = busy;

        case (state)
            IDLE: begin
                if (beat && !mute) begin
                    state_d   = TONE;
                    phase_d   = '0;
                    dur_d     = '0;
                    accent_d  = accent;
                    speaker_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            TONE: begin
                if (mute) begin
                    state_d   = IDLE;
                    phase_d   = '0;
                    dur_d     = '0;
                    speaker_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (beat) begin
                    phase_d   = '0;
                    dur_d     = '0;
                    accent_d  = accent;
                    speaker_d = 1'b0;
                    busy_d    = 1'b1;
                end else if (dur_cnt == DW'(BEEP_CYCLES - 1)) begin
                    state_d   = IDLE;
                    phase_d   = '0;
                    dur_d     = '0;
                    speaker_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    dur_d = dur_cnt + DW'(1);
                    if (phase_cnt == half_last) begin
                        phase_d   = '0;
                        speaker_d = ~speaker;
                    end else begin
                        phase_d = phase_cnt + PW'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                speaker_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_click_tone_generator.sv
// Bench for click_tone_generator at 8 kHz: HALF_N=4, HALF_A=2, BEEP_CYCLES=16.
module tb_click_tone_generator;

    localparam int unsigned FREQ      = 8000;
    localparam int unsigned TONE_HZ   = 1000;
    localparam int unsigned ACCENT_HZ = 2000;
    localparam int unsigned BEEP_MS   = 2;
    localparam int BEEP = 16;

    logic sys_clk = 1'b0;
    logic rst, beat, accent, mute;
    logic speaker, busy;

    click_tone_generator #(
        .FREQ(FREQ), .TONE_HZ(TONE_HZ), .ACCENT_HZ(ACCENT_HZ), .BEEP_MS(BEEP_MS)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .beat(beat), .accent(accent), .mute(mute),
        .speaker(speaker), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic beat;
        logic accent;
        logic mute;
        logic spk;
        logic bsy;
    } vec_t;

    typedef struct {
        logic  spk;
        logic  bsy;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, req, $time);
        end
    endtask

    // Push expectation, drive inputs for one cycle, pop and compare after the edge
    task automatic step(input logic b, input logic a, input logic m,
                        input logic es, input logic eb, input string name);
        exp_t e;
        e.spk = es; e.bsy = eb; e.name = name;
        exp_q.push_back(e);
        beat = b; accent = a; mute = m;
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        check_bit({e.name, ".speaker"}, speaker, e.spk);
        check_bit({e.name, ".busy"}, busy, e.bsy);
    endtask

    task automatic add(input logic b, input logic a, input logic m, input logic s, input logic bz);
        vec_t v;
        v.beat = b; v.accent = a; v.mute = m; v.spk = s; v.bsy = bz;
        vecs.push_back(v);
    endtask

    // Expected speaker level for output cycle i of a burst with runs of 'half' cycles, starting low
    function automatic logic tone_bit(input int i, input int half);
        return logic'((i / half) % 2);
    endfunction

    initial begin
        rst = 1'b1; beat = 1'b0; accent = 1'b0; mute = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_bit("reset.speaker", speaker, 1'b1);
        check_bit("reset.busy", busy, 1'b0);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 0);
        // Normal beat
        add(1, 0, 0, 0, 1);
        for (int i = 1; i < BEEP; i++) add(0, 0, 0, tone_bit(i, 4), 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0);
        // Accented beat
        add(1, 1, 0, 0, 1);
        for (int i = 1; i < BEEP; i++) add(0, 0, 0, tone_bit(i, 2), 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0);
        // Retrigger at cycle 6 with accent: 22 busy cycles total
        add(1, 0, 0, 0, 1);
        for (int i = 1; i < 6; i++) add(0, 1, 0, tone_bit(i, 4), 1);
        add(1, 1, 0, 0, 1);
        for (int i = 1; i < BEEP; i++) add(0, 0, 0, tone_bit(i, 2), 1);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 1, 0);
        // Beat while muted in IDLE is ignored
        add(1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0);
        // Mute raised at cycle 5 of a burst
        add(1, 0, 0, 0, 1);
        for (int i = 1; i < 5; i++) add(0, 0, 0, tone_bit(i, 4), 1);
        add(0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0);
        // Beat and mute together in TONE: burst ends, no retrigger
        add(1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1);
        add(1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].beat, vecs[i].accent, vecs[i].mute, vecs[i].spk, vecs[i].bsy,
                 $sformatf("vec%0d", i));

        // Async reset mid-burst
        step(1, 0, 0, 0, 1, "arst.start");
        step(0, 0, 0, 0, 1, "arst.c1");
        step(0, 0, 0, 0, 1, "arst.c2");
        #3;
        rst = 1'b1;
        #1;
        check_bit("arst.async.speaker", speaker, 1'b1);
        check_bit("arst.async.busy", busy, 1'b0);
        @(posedge sys_clk);
        #1;
        check_bit("arst.held.speaker", speaker, 1'b1);
        check_bit("arst.held.busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, $sformatf("arst.idle%0d", i));
        step(1, 0, 0, 0, 1, "arst.newbeat");
        for (int i = 1; i < BEEP; i++) step(0, 0, 0, tone_bit(i, 4), 1, $sformatf("arst.b%0d", i));
        step(0, 0, 0, 1, 0, "arst.end");

        // Beats in consecutive cycles keep restarting the pattern
        step(1, 0, 0, 0, 1, "rapid.0");
        step(1, 1, 0, 0, 1, "rapid.1");
        step(0, 0, 0, 0, 1, "rapid.2");
        step(0, 0, 0, 1, 1, "rapid.3");
        step(0, 0, 0, 1, 1, "rapid.4");
        step(0, 0, 0, 0, 1, "rapid.5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/click_tone_generator.md
Name: click_tone_generator

Overview:
Downstream stage of the metronome beat timer. It converts each one-cycle beat strobe into an audible square-wave burst on the piezo speaker pin, at a fixed duration. Accented beats (bar start) use a higher pitch. The speaker output idles high, matching the existing board wiring, so the beat timer no longer drives the pin directly.

Parameters:
FREQ, 24_000_000, sys_clk frequency in Hz
TONE_HZ, 880, pitch of normal beats in Hz
ACCENT_HZ, 1760, pitch of accented beats in Hz
BEEP_MS, 60, burst length in ms
Derived (localparam):
- HALF_N = FREQ/(2*TONE_HZ)
- HALF_A = FREQ/(2*ACCENT_HZ)
- BEEP_CYCLES = (FREQ/1000)*BEEP_MS
- Elaboration error if HALF_N<1, HALF_A<1 or BEEP_CYCLES<2.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
beat  input  1  one-cycle strobe from the beat timer; each high cycle is one beat
accent  input  1  qualifies beat; sampled only in the cycle beat=1
mute  input  1  level; while high no burst starts and any running burst stops
speaker  output  1  square-wave drive; idle level 1
busy  output  1  high while a burst is in progress

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, speaker=1, busy=0
  - phase_cnt, dur_cnt and accent_q cleared
- Counter widths: phase_cnt is $clog2(max(HALF_N,HALF_A)+1) bits; dur_cnt is $clog2(BEEP_CYCLES+1) bits. Neither counter wraps beyond its terminal value.
- States: IDLE, TONE. Registered outputs only, no combinational path from input to output.
- IDLE:
  - beat=1 and mute=0 at edge k: at edge k go to TONE, speaker<=0, busy<=1, phase_cnt<=0, dur_cnt<=0, accent_q<=accent. Latency from the beat cycle to speaker low is 1 edge.
  - beat=1 and mute=1: ignored; state stays IDLE.
- TONE, each edge:
  - dur_cnt increments.
  - phase_cnt increments. When phase_cnt==HALF-1 (HALF = accent_q ? HALF_A : HALF_N), speaker toggles and phase_cnt<=0. Speaker therefore alternates runs of HALF cycles, starting with a low run.
  - When dur_cnt==BEEP_CYCLES-1: go to IDLE, speaker<=1, busy<=0. This takes priority over the toggle. speaker/busy are in burst state for exactly BEEP_CYCLES cycles.
- Priority in TONE (highest first):
  1. mute=1: go to IDLE, speaker<=1, busy<=0 next edge; any beat in the same cycle is discarded.
  2. beat=1: retrigger. Same actions as the IDLE start (counters zeroed, speaker<=0, accent re-latched); full BEEP_CYCLES from this edge.
  3. Normal counting.
- accent is ignored when beat=0. A pitch change mid-burst occurs only by retrigger.
- rst mid-burst: immediately speaker=1, busy=0; no residual burst after release.
- The beat timer guarantees a beat period > BEEP_CYCLES. The block must still behave per retrigger rules if that guarantee is violated.

Test Plan:
Override FREQ=8000, TONE_HZ=1000, ACCENT_HZ=2000, BEEP_MS=2, giving HALF_N=4, HALF_A=2, BEEP_CYCLES=16.
1. Reset: rst=1 then release with beat=0 for 10 cycles -> speaker=1, busy=0 throughout.
2. Normal beat: beat=1, accent=0 for one cycle -> starting the next edge, speaker = 0000 1111 0000 1111; busy=1 for exactly 16 cycles; then speaker=1, busy=0.
3. Accented beat: beat=1, accent=1 -> speaker = (0011) x4 over 16 cycles, then 1; busy high for 16 cycles.
4. Retrigger: beat at cycle 0 (accent=0), second beat at cycle 6 with accent=1 -> from cycle 7, pattern restarts as 0011...; busy stays high continuously until cycle 22, total 22 busy cycles.
5. Mute: mute=1 with a beat -> no burst, busy=0. Mute raised at cycle 5 of a burst -> speaker=1, busy=0 from the next edge. Beat and mute in the same TONE cycle -> burst ends, no retrigger.
6. Async reset mid-burst: rst pulsed at cycle 3 between clock edges -> speaker=1, busy=0 before the next edge; stays idle after release until a new beat.
